rv_iopmp_bram_width_bridge: RTL and testbench

//  Bridges the narrow IOPMP regmap entry port to the wide entry-table BRAM.

---
 rtl/rv_iopmp_bram_pkg.sv | 31 +++
 rtl/rv_iopmp_lane_mux.sv | 41 ++++
 rtl/rv_iopmp_bram_width_bridge.sv | 238 +++++++++++++++++++++++
 tb/tb_rv_iopmp_bram_width_bridge.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_iopmp_bram_pkg.sv
// ---------------------------------------------------------------------------
// rv_iopmp_bram_pkg
// Shared types and helpers for the IOPMP entry-table width bridge.
//   bridge_state_e : bridge FSM states
//   CNT_W          : width of the BRAM read-latency down-counter
//   lane_of()      : lane index of a narrow word address
//   is_pow2()      : parameter legality helper
// ---------------------------------------------------------------------------
package rv_iopmp_bram_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      RESP    = 2'd2
   } bridge_state_e;

   // Read latency is limited to 1..3, so two counter bits always suffice.
   localparam int unsigned CNT_W            = 2;
   localparam int unsigned MIN_READ_LATENCY = 1;
   localparam int unsigned MAX_READ_LATENCY = 3;

   function automatic int unsigned lane_of(input int unsigned addr,
                                           input int unsigned ratio);
      return addr % ratio;
   endfunction

   function automatic bit is_pow2(input int unsigned v);
      return (v != 0) && ((v & (v - 1)) == 0);
   endfunction

endpackage

// File: rtl/rv_iopmp_lane_mux.sv
// ---------------------------------------------------------------------------
// rv_iopmp_lane_mux
// Combinational lane steering between a narrow word and a wide BRAM line.
//   rd_line_i / rd_lane_i -> rd_word_o : extract one lane from a line
//   wr_data_i             -> wr_line_o : narrow word replicated on every lane
//   wr_be_i / wr_lane_i   -> wr_be_o   : byte enables placed on the selected
//                                        lane, zero on all other lanes
// ---------------------------------------------------------------------------
module rv_iopmp_lane_mux #(
   parameter  int unsigned OUT_WIDTH   = 32,
   parameter  int unsigned BRAM_DWIDTH = 128,
   localparam int unsigned RATIO       = BRAM_DWIDTH / OUT_WIDTH,
   localparam int unsigned LANE_W      = $clog2(RATIO),
   localparam int unsigned BE_W        = OUT_WIDTH / 8
) (
   input  logic [BRAM_DWIDTH-1:0]   rd_line_i,
   input  logic [LANE_W-1:0]        rd_lane_i,
   output logic [OUT_WIDTH-1:0]     rd_word_o,
   input  logic [LANE_W-1:0]        wr_lane_i,
   input  logic [OUT_WIDTH-1:0]     wr_data_i,
   input  logic [BE_W-1:0]          wr_be_i,
   output logic [BRAM_DWIDTH-1:0]   wr_line_o,
   output logic [BRAM_DWIDTH/8-1:0] wr_be_o
);

   always_comb begin
      rd_word_o = '0;
      wr_line_o = '0;
      wr_be_o   = '0;
      for (int k = 0; k < RATIO; k++) begin
         wr_line_o[k*OUT_WIDTH +: OUT_WIDTH] = wr_data_i;
         if (rd_lane_i == LANE_W'(k)) begin
            rd_word_o = rd_line_i[k*OUT_WIDTH +: OUT_WIDTH];
         end
         if (wr_lane_i == LANE_W'(k)) begin
            wr_be_o[k*BE_W +: BE_W] = wr_be_i;
         end
      end
   end

endmodule

// File: rtl/rv_iopmp_bram_width_bridge.sv
// ---------------------------------------------------------------------------
// rv_iopmp_bram_width_bridge
// Bridges the narrow IOPMP regmap entry port to the wide entry-table BRAM.
// One transaction outstanding at a time; byte-enabled narrow writes are
// turned into lane-masked line writes, reads extract one lane of a line.
//
// Optional feature macro: RV_IOPMP_BRAM_RDCACHE_EN
//   Defined   : one-line read cache (data, tag, valid). Every completed BRAM
//               read fills it; read hits skip the BRAM and respond after one
//               cycle; writes to the cached line update it (write-through).
//   Undefined : every read goes to the BRAM.
//
// Ports
//   clk_i, rst_i                   clock, synchronous active-high reset
//   req_valid_i/req_ready_o        narrow request handshake
//   req_we_i, req_addr_i           1 = write; word address (LSBs = lane)
//   req_wdata_i, req_be_i          write data and byte enables
//   rsp_valid_o/rsp_ready_i        response handshake
//   rsp_rdata_o                    read data (0 on write ack)
//   en_bram_o, we_bram_o           BRAM enable / write strobe
//   addr_bram_o                    BRAM line address
//   din_bram_o, be_bram_o          BRAM write data / byte enables
//   dout_bram_i                    BRAM read data
//
// state   | meaning
// IDLE    | ready for a request; BRAM strobes driven in the accept cycle
// RD_WAIT | waiting READ_LATENCY cycles for dout_bram_i
// RESP    | response held until rsp_ready_i
// ---------------------------------------------------------------------------
module rv_iopmp_bram_width_bridge
   import rv_iopmp_bram_pkg::*;
#(
   parameter  int unsigned OUT_WIDTH    = 32,
   parameter  int unsigned BRAM_DWIDTH  = 128,
   parameter  int unsigned DEPTH        = 8,
   parameter  int unsigned READ_LATENCY = 1,
   localparam int unsigned RATIO        = BRAM_DWIDTH / OUT_WIDTH,
   localparam int unsigned LANE_W       = $clog2(RATIO),
   localparam int unsigned LINE_W       = $clog2(DEPTH),
   localparam int unsigned ADDR_W       = LINE_W + LANE_W,
   localparam int unsigned BE_W         = OUT_WIDTH / 8,
   localparam int unsigned LBE_W        = BRAM_DWIDTH / 8
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   req_valid_i,
   output logic                   req_ready_o,
   input  logic                   req_we_i,
   input  logic [ADDR_W-1:0]      req_addr_i,
   input  logic [OUT_WIDTH-1:0]   req_wdata_i,
   input  logic [BE_W-1:0]        req_be_i,
   output logic                   rsp_valid_o,
   input  logic                   rsp_ready_i,
   output logic [OUT_WIDTH-1:0]   rsp_rdata_o,
   output logic                   en_bram_o,
   output logic                   we_bram_o,
   output logic [LINE_W-1:0]      addr_bram_o,
   output logic [BRAM_DWIDTH-1:0] din_bram_o,
   output logic [LBE_W-1:0]       be_bram_o,
   input  logic [BRAM_DWIDTH-1:0] dout_bram_i
);

   if ((OUT_WIDTH == 0) || (OUT_WIDTH % 8 != 0)) begin : g_bad_out_width
      $error("OUT_WIDTH must be a non-zero multiple of 8");
   end
   if (BRAM_DWIDTH % OUT_WIDTH != 0) begin : g_bad_bram_width
      $error("OUT_WIDTH must divide BRAM_DWIDTH");
   end
   if (!is_pow2(RATIO) || (RATIO < 2)) begin : g_bad_ratio
      $error("BRAM_DWIDTH/OUT_WIDTH must be a power of 2 and at least 2");
   end
   if (!is_pow2(DEPTH) || (DEPTH < 2)) begin : g_bad_depth
      $error("DEPTH must be a power of 2 and at least 2");
   end
   if ((READ_LATENCY < MIN_READ_LATENCY) || (READ_LATENCY > MAX_READ_LATENCY)) begin : g_bad_lat
      $error("READ_LATENCY must be within 1..3");
   end

   bridge_state_e          state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [LANE_W-1:0]      lane_q, lane_d;
   logic [OUT_WIDTH-1:0]   rsp_q, rsp_d;

   logic [LINE_W-1:0]      req_line;
   logic [LANE_W-1:0]      req_lane;
   logic [BRAM_DWIDTH-1:0] mux_rd_line;
   logic [LANE_W-1:0]      mux_rd_lane;
   logic [OUT_WIDTH-1:0]   mux_word;
   logic [BRAM_DWIDTH-1:0] rep_line;
   logic [LBE_W-1:0]       be_line;
   logic                   c_hit;

   assign req_lane = LANE_W'(lane_of(32'(req_addr_i), RATIO));
   assign req_line = req_addr_i[ADDR_W-1:LANE_W];

`ifdef RV_IOPMP_BRAM_RDCACHE_EN
   logic [BRAM_DWIDTH-1:0] c_line_q, c_line_d;
   logic [LINE_W-1:0]      c_tag_q, c_tag_d;
   logic                   c_vld_q, c_vld_d;
   logic [LINE_W-1:0]      line_q, line_d;

   assign c_hit = c_vld_q && (c_tag_q == req_line);

   // One extractor serves both sources: the BRAM while a read is landing,
   // the cached line when a hit is looked up in IDLE.
   assign mux_rd_line = (state_q == RD_WAIT) ? dout_bram_i : c_line_q;
   assign mux_rd_lane = (state_q == RD_WAIT) ? lane_q : req_lane;
`else
   assign c_hit       = 1'b0;
   assign mux_rd_line = dout_bram_i;
   assign mux_rd_lane = lane_q;
`endif

   rv_iopmp_lane_mux #(
      .OUT_WIDTH   (OUT_WIDTH),
      .BRAM_DWIDTH (BRAM_DWIDTH)
   ) u_lane_mux (
      .rd_line_i (mux_rd_line),
      .rd_lane_i (mux_rd_lane),
      .rd_word_o (mux_word),
      .wr_lane_i (req_lane),
      .wr_data_i (req_wdata_i),
      .wr_be_i   (req_be_i),
      .wr_line_o (rep_line),
      .wr_be_o   (be_line)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      lane_d      = lane_q;
      rsp_d       = rsp_q;
      req_ready_o = 1'b0;
      rsp_valid_o = 1'b0;
      en_bram_o   = 1'b0;
      we_bram_o   = 1'b0;
      addr_bram_o = '0;
      din_bram_o  = '0;
      be_bram_o   = '0;
`ifdef RV_IOPMP_BRAM_RDCACHE_EN
      c_line_d    = c_line_q;
      c_tag_d     = c_tag_q;
      c_vld_d     = c_vld_q;
      line_d      = line_q;
`endif

      case (state_q)
         IDLE: begin
            req_ready_o = 1'b1;
            // Accepting while in reset would strobe the BRAM for a
            // transaction that is dropped anyway.
            if (req_valid_i && !rst_i) begin
               lane_d = req_lane;
               if (req_we_i) begin
                  en_bram_o   = 1'b1;
                  we_bram_o   = 1'b1;
                  addr_bram_o = req_line;
                  din_bram_o  = rep_line;
                  be_bram_o   = be_line;
                  rsp_d       = '0;
                  state_d     = RESP;
`ifdef RV_IOPMP_BRAM_RDCACHE_EN
                  if (c_hit) begin
                     for (int b = 0; b < LBE_W; b++) begin
                        if (be_line[b]) begin
                           c_line_d[b*8 +: 8] = rep_line[b*8 +: 8];
                        end
                     end
                  end
`endif
               end else if (c_hit) begin
                  rsp_d   = mux_word;
                  state_d = RESP;
               end else begin
                  en_bram_o   = 1'b1;
                  addr_bram_o = req_line;
                  cnt_d       = CNT_W'(READ_LATENCY - 1);
                  state_d     = RD_WAIT;
`ifdef RV_IOPMP_BRAM_RDCACHE_EN
                  line_d      = req_line;
`endif
               end
            end
         end
         RD_WAIT: begin
            if (cnt_q == '0) begin
               rsp_d   = mux_word;
               state_d = RESP;
`ifdef RV_IOPMP_BRAM_RDCACHE_EN
               c_line_d = dout_bram_i;
               c_tag_d  = line_q;
               c_vld_d  = 1'b1;
`endif
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         RESP: begin
            rsp_valid_o = 1'b1;
            if (rsp_ready_i) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign rsp_rdata_o = rsp_valid_o ? rsp_q : '0;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         lane_q   <= '0;
         rsp_q    <= '0;
`ifdef RV_IOPMP_BRAM_RDCACHE_EN
         c_line_q <= '0;
         c_tag_q  <= '0;
         c_vld_q  <= 1'b0;
         line_q   <= '0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         lane_q   <= lane_d;
         rsp_q    <= rsp_d;
`ifdef RV_IOPMP_BRAM_RDCACHE_EN
         c_line_q <= c_line_d;
         c_tag_q  <= c_tag_d;
         c_vld_q  <= c_vld_d;
         line_q   <= line_d;
`endif
      end
   end

endmodule

// File: tb/tb_rv_iopmp_bram_width_bridge.sv
// ---------------------------------------------------------------------------
// tb_rv_iopmp_bram_width_bridge
// Word-level reference model (flat array of narrow words, transaction
// latency bookkeeping, optional one-line cache tag) compared against the
// bridge every cycle, plus directed literal checks and randomized traffic.
// A behavioural BRAM with READ_LATENCY pipeline sits on the wide side.
// ---------------------------------------------------------------------------
module tb_rv_iopmp_bram_width_bridge;

   localparam int OW     = 32;
   localparam int BW     = 128;
   localparam int DEPTH  = 8;
   localparam int RL     = 2;
   localparam int RATIO  = BW / OW;
   localparam int LINE_W = 3;
   localparam int AW     = 5;
   localparam int BEW    = OW / 8;
   localparam int LBEW   = BW / 8;

   logic              clk_i;
   logic              rst_i;
   logic              req_valid_i;
   logic              req_ready_o;
   logic              req_we_i;
   logic [AW-1:0]     req_addr_i;
   logic [OW-1:0]     req_wdata_i;
   logic [BEW-1:0]    req_be_i;
   logic              rsp_valid_o;
   logic              rsp_ready_i;
   logic [OW-1:0]     rsp_rdata_o;
   logic              en_bram_o;
   logic              we_bram_o;
   logic [LINE_W-1:0] addr_bram_o;
   logic [BW-1:0]     din_bram_o;
   logic [LBEW-1:0]   be_bram_o;
   logic [BW-1:0]     dout_bram_i;

   rv_iopmp_bram_width_bridge #(
      .OUT_WIDTH    (OW),
      .BRAM_DWIDTH  (BW),
      .DEPTH        (DEPTH),
      .READ_LATENCY (RL)
   ) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .req_valid_i (req_valid_i),
      .req_ready_o (req_ready_o),
      .req_we_i    (req_we_i),
      .req_addr_i  (req_addr_i),
      .req_wdata_i (req_wdata_i),
      .req_be_i    (req_be_i),
      .rsp_valid_o (rsp_valid_o),
      .rsp_ready_i (rsp_ready_i),
      .rsp_rdata_o (rsp_rdata_o),
      .en_bram_o   (en_bram_o),
      .we_bram_o   (we_bram_o),
      .addr_bram_o (addr_bram_o),
      .din_bram_o  (din_bram_o),
      .be_bram_o   (be_bram_o),
      .dout_bram_i (dout_bram_i)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // Behavioural BRAM.
   logic [BW-1:0] bram    [DEPTH];
   logic [BW-1:0] rd_pipe [RL];

   always @(posedge clk_i) begin
      if (en_bram_o) begin
         if (we_bram_o) begin
            for (int b = 0; b < LBEW; b++) begin
               if (be_bram_o[b]) bram[addr_bram_o][b*8 +: 8] <= din_bram_o[b*8 +: 8];
            end
         end else begin
            rd_pipe[0] <= bram[addr_bram_o];
         end
      end
      for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign dout_bram_i = rd_pipe[RL-1];

   // Reference model state.
   logic [OW-1:0]     ref_w [DEPTH*RATIO];
   int                n_chk = 0;
   int                n_err = 0;
   bit                chk_on = 0;
   bit                m_busy = 0;
   int                m_age = 0;
   int                m_lat = 0;
   logic [OW-1:0]     m_data = '0;
   bit                m_rd_miss = 0;
   logic [LINE_W-1:0] m_line = '0;
   bit                m_cv = 0;
   logic [LINE_W-1:0] m_tag = '0;
   bit                acc_flag = 0;
   logic              s_en;
   logic [LINE_W-1:0] s_addr;
   logic [BW-1:0]     s_din;
   logic [LBEW-1:0]   s_be;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk_i) begin : compare
      int               ln;
      int               lane;
      bit               hit;
      bit               e_acc;
      bit               e_en;
      bit               e_rv;
      logic [BW-1:0]    e_din;
      logic [LBEW-1:0]  e_be;
      acc_flag = 0;
      if (chk_on) begin
         ln    = int'(req_addr_i) / RATIO;
         lane  = int'(req_addr_i) % RATIO;
         hit   = m_cv && (m_tag == LINE_W'(ln));
         e_acc = req_valid_i && !m_busy && !rst_i;
         e_en  = e_acc && (req_we_i || !hit);
         e_rv  = m_busy && (m_age >= m_lat);
         check("req_ready", 128'(req_ready_o), 128'(!m_busy));
         check("rsp_valid", 128'(rsp_valid_o), 128'(e_rv));
         if (e_rv) check("rsp_rdata", 128'(rsp_rdata_o), 128'(m_data));
         check("en_bram", 128'(en_bram_o), 128'(e_en));
         if (e_en) begin
            check("we_bram", 128'(we_bram_o), 128'(req_we_i));
            check("addr_bram", 128'(addr_bram_o), 128'(ln));
            if (req_we_i) begin
               e_din = {RATIO{req_wdata_i}};
               e_be  = LBEW'(req_be_i) << (BEW * lane);
               check("din_bram", din_bram_o, e_din);
               check("be_bram", 128'(be_bram_o), 128'(e_be));
            end
         end else begin
            check("we_bram_quiet", 128'(we_bram_o), 128'(0));
         end
         if (e_acc) begin
            s_en = en_bram_o; s_addr = addr_bram_o; s_din = din_bram_o; s_be = be_bram_o;
         end
         if (rst_i) begin
            m_busy = 0;
            m_cv   = 0;
         end else if (m_busy) begin
            if (e_rv && rsp_ready_i) begin
               m_busy = 0;
`ifdef RV_IOPMP_BRAM_RDCACHE_EN
               if (m_rd_miss) begin
                  m_cv  = 1;
                  m_tag = m_line;
               end
`endif
            end else begin
               m_age++;
            end
         end else if (e_acc) begin
            acc_flag = 1;
            m_busy   = 1;
            m_age    = 1;
            m_line   = LINE_W'(ln);
            if (req_we_i) begin
               for (int b = 0; b < BEW; b++) begin
                  if (req_be_i[b]) ref_w[req_addr_i][b*8 +: 8] = req_wdata_i[b*8 +: 8];
               end
               m_data    = '0;
               m_lat     = 1;
               m_rd_miss = 0;
            end else begin
               m_data    = ref_w[req_addr_i];
               m_lat     = hit ? 1 : RL + 1;
               m_rd_miss = !hit;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic txn(input bit we, input int a, input logic [OW-1:0] wd,
                      input logic [BEW-1:0] be, input int hold,
                      output logic [OW-1:0] rd, output int lat);
      int n;
      req_valid_i = 1; req_we_i = we; req_addr_i = AW'(a);
      req_wdata_i = wd; req_be_i = be; rsp_ready_i = 0;
      n = 0;
      do begin
         tick();
         n++;
      end while (!acc_flag && n < 20);
      if (!acc_flag) check("accept_timeout", 128'(0), 128'(1));
      req_valid_i = 0;
      lat = 1;
      while (!rsp_valid_o && lat < 20) begin
         tick();
         lat++;
      end
      rd = rsp_rdata_o;
      if (hold > 0) begin
         req_valid_i = 1; req_we_i = 0; req_addr_i = AW'(a ^ 1);
         for (int i = 0; i < hold; i++) begin
            tick();
            check("bp_rsp_valid", 128'(rsp_valid_o), 128'(1));
            check("bp_rdata", 128'(rsp_rdata_o), 128'(rd));
            check("bp_ready", 128'(req_ready_o), 128'(0));
            check("bp_no_bram", 128'(en_bram_o), 128'(0));
         end
         req_valid_i = 0;
      end
      rsp_ready_i = 1;
      tick();
      rsp_ready_i = 0;
   endtask

   initial begin : wdog
      #300000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin : main
      logic [OW-1:0] rd;
      int            lat;
      int            n;
      logic [OW-1:0] w;
      rst_i = 1; req_valid_i = 0; req_we_i = 0; req_addr_i = '0;
      req_wdata_i = '0; req_be_i = '0; rsp_ready_i = 0;
      for (int l = 0; l < DEPTH; l++) begin
         for (int k = 0; k < RATIO; k++) begin
            w = $urandom;
            ref_w[l*RATIO + k] = w;
            bram[l][k*OW +: OW] = w;
         end
      end
      for (int i = 0; i < RL; i++) rd_pipe[i] = '0;

      repeat (3) tick();
      check("rst_req_ready", 128'(req_ready_o), 128'(1));
      check("rst_rsp_valid", 128'(rsp_valid_o), 128'(0));
      check("rst_en_bram", 128'(en_bram_o), 128'(0));
      check("rst_we_bram", 128'(we_bram_o), 128'(0));
      check("rst_rdata", 128'(rsp_rdata_o), 128'(0));
      chk_on = 1;
      rst_i  = 0;
      tick();

      // Directed write addr 6 -> line 1, lane 2.
      txn(1, 6, 32'hDEADBEEF, 4'hF, 0, rd, lat);
      check("wr6_addr", 128'(s_addr), 128'(1));
      check("wr6_be", 128'(s_be), 128'(16'h0F00));
      check("wr6_din_lane2", 128'(s_din[95:64]), 128'(32'hDEADBEEF));
      check("wr6_ack_rdata", 128'(rd), 128'(0));
      check("wr6_ack_lat", 128'(lat), 128'(1));

      // Directed read addr 6 with backpressure.
      txn(0, 6, '0, '0, 5, rd, lat);
      check("rd6_rdata", 128'(rd), 128'(32'hDEADBEEF));
      check("rd6_lat", 128'(lat), 128'(3));
      check("rd6_en", 128'(s_en), 128'(1));

      // Byte-merge sequence on line 1 (cache hit path when enabled).
      txn(1, 5, 32'h11223344, 4'hF, 0, rd, lat);
      txn(0, 4, '0, '0, 0, rd, lat);
      txn(0, 5, '0, '0, 0, rd, lat);
      check("rd5_rdata", 128'(rd), 128'(32'h11223344));
`ifdef RV_IOPMP_BRAM_RDCACHE_EN
      check("rd5_hit_lat", 128'(lat), 128'(1));
      check("rd5_hit_no_en", 128'(s_en), 128'(0));
`else
      check("rd5_lat", 128'(lat), 128'(3));
      check("rd5_en", 128'(s_en), 128'(1));
`endif
      txn(1, 5, 32'hAAAABBBB, 4'h3, 0, rd, lat);
      check("wr5_be", 128'(s_be), 128'(16'h0030));
      txn(0, 5, '0, '0, 2, rd, lat);
      check("rd5_merged", 128'(rd), 128'(32'h1122BBBB));

      // Write with no byte enables still strobes and is acked.
      txn(1, 7, 32'h55555555, 4'h0, 0, rd, lat);
      check("wr7_be0_en", 128'(s_en), 128'(1));
      check("wr7_be0_be", 128'(s_be), 128'(0));
      check("wr7_be0_ack", 128'(lat), 128'(1));

      // Reset while a read is waiting on the BRAM.
      req_valid_i = 1; req_we_i = 0; req_addr_i = AW'(8);
      n = 0;
      do begin
         tick();
         n++;
      end while (!acc_flag && n < 20);
      if (!acc_flag) check("accept_timeout", 128'(0), 128'(1));
      req_valid_i = 0;
      rst_i = 1;
      tick();
      rst_i = 0;
      rsp_ready_i = 1;
      for (int i = 0; i < 6; i++) begin
         check("rst_drop_rsp", 128'(rsp_valid_o), 128'(0));
         tick();
      end
      rsp_ready_i = 0;
      txn(0, 5, '0, '0, 0, rd, lat);
      check("post_rst_rdata", 128'(rd), 128'(32'h1122BBBB));
      check("post_rst_en", 128'(s_en), 128'(1));
      check("post_rst_lat", 128'(lat), 128'(3));

      // Randomized traffic, biased to lines 1..2 for cache hits.
      for (int c = 0; c < 1500; c++) begin
         if (!req_valid_i || acc_flag) begin
            req_valid_i = ($urandom % 3) != 0;
            req_we_i    = ($urandom % 3) == 0;
            req_addr_i  = (($urandom % 4) == 0) ? AW'($urandom) : AW'($urandom_range(4, 11));
            req_wdata_i = $urandom;
            req_be_i    = BEW'($urandom);
         end
         rsp_ready_i = ($urandom % 4) != 0;
         rst_i       = ($urandom % 200) == 0;
         tick();
      end
      req_valid_i = 0;
      rst_i       = 0;
      rsp_ready_i = 1;
      repeat (8) tick();

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
